lsu_subword: RTL

- Load/store unit that sits directly upstream of the word-wide data memory, between the pipeline MEM stage and the memory's address/write_data/mem_read/mem_write/read_data interface.
- Converts RV loads and stores (byte, halfword, word) into whole-word memory operations.
- Loads: extracts and sign- or zero-extends the selected bytes.
- Sub-word stores: performed as read-modify-write, because the memory has no byte enables.
- Flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_subword_if.sv | 48 ++++
 rtl/lsu_subword.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lsu_subword_if.sv
// lsu_subword_if
//   Bundles the request/response handshake and the word-wide memory port of
//   the sub-word load/store unit.
//
//   Handshake: a request transfers on a rising clock edge where req_valid and
//   req_ready are both high. The requester holds the req_* fields stable while
//   req_valid is high. rsp_valid is a single-cycle pulse with no backpressure.
//   rsp_rdata and rsp_err are meaningful only while rsp_valid is high.
//
//   Ports (signals):
//     req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//     rsp_valid/rsp_rdata/rsp_err                               : response
//     mem_addr/mem_wdata/mem_read/mem_write/mem_rdata           : memory port
//
//   Modports:
//     slave  : the load/store unit
//     master : the pipeline and the memory that surround it
interface lsu_subword_if #(
    parameter int AW = 64,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_subword.sv
// lsu_subword
//   Load/store unit placed in front of a word-wide data memory that has no
//   byte enables. Loads read a whole word and extract/extend the addressed
//   byte or halfword. Word stores write directly; byte/halfword stores read the
//   word, merge the new lane and write it back. Misaligned or illegal requests
//   are answered with rsp_err without touching memory.
//
//   Ports:
//     clk      : clock
//     rst_n    : asynchronous active-low reset
//     bus      : lsu_subword_if.slave (request, response and memory port)
//     o_state  : current FSM state, for observation
module lsu_subword #(
    parameter int AW = 64,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_subword_if.slave       bus,
    output logic [2:0]         o_state
);

    if (DW != 32) begin : g_dw_check
        $error("lsu_subword supports only DW = 32");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_RD   = 3'd1,
        S_LD_DATA = 3'd2,
        S_ST_WR   = 3'd3,
        S_RMW_RD  = 3'd4,
        S_RMW_WR  = 3'd5,
        S_RESP    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t        r_state;
    logic [2:0]    r_funct3;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic          w_accept;
    logic          w_err;
    state_t        w_accept_state;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_load;
    logic [DW-1:0] w_merge;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // Legality of the incoming request. BU/HU exist only as loads.
    always_comb begin
        w_err = 1'b0;
        case (bus.req_funct3)
            3'b000:  w_err = 1'b0;
            3'b001:  w_err = bus.req_addr[0];
            3'b010:  w_err = (bus.req_addr[1:0] != 2'b00);
            3'b100:  w_err = bus.req_we;
            3'b101:  w_err = bus.req_we | bus.req_addr[0];
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_accept_state = S_IDLE;
        if (w_err)
            w_accept_state = S_ERR;
        else if (!bus.req_we)
            w_accept_state = S_LD_RD;
        else if (bus.req_funct3 == 3'b010)
            w_accept_state = S_ST_WR;
        else
            w_accept_state = S_RMW_RD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_state  <= w_accept_state;
                    end
                end
                S_LD_RD:   r_state <= S_LD_DATA;
                S_LD_DATA: r_state <= S_IDLE;
                S_ST_WR:   r_state <= S_RESP;
                S_RMW_RD:  r_state <= S_RMW_WR;
                S_RMW_WR:  r_state <= S_RESP;
                S_RESP:    r_state <= S_IDLE;
                S_ERR:     r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Lane selection from the word returned by memory.
    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
    end

    assign w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_load = bus.mem_rdata;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = bus.mem_rdata;
        endcase
    end

    // Read-modify-write merge: only byte (000) and halfword (001) stores
    // reach RMW_WR, so funct3[0] alone picks the lane size.
    always_comb begin
        w_merge = bus.mem_rdata;
        if (!r_funct3[0]) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    // All outputs are decoded from the state register so strobes drop the
    // moment reset is asserted.
    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_LD_DATA) || (r_state == S_RESP) || (r_state == S_ERR);
    assign bus.rsp_err   = (r_state == S_ERR);
    assign bus.rsp_rdata = (r_state == S_LD_DATA) ? w_load : '0;
    assign bus.mem_read  = (r_state == S_LD_RD) || (r_state == S_RMW_RD);
    assign bus.mem_write = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
    assign bus.mem_addr  = (r_state == S_IDLE) ? '0 : {r_addr[AW-1:2], 2'b00};
    assign bus.mem_wdata = (r_state == S_ST_WR)  ? r_wdata :
                           (r_state == S_RMW_WR) ? w_merge : '0;
    assign o_state       = r_state;

endmodule
